// File: rtl/ksa_pkg.sv
// Shared definitions for the pipelined Kogge-Stone adder family.
// The per-stage record depends on the operand width, so each adder
// declares it locally. This package holds the width-independent helpers.
package ksa_pkg;

  // Number of prefix levels a Kogge-Stone tree needs for a given width.
  function automatic int levels_f(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/ksa_prefix_level.sv
// One combinational Kogge-Stone prefix level.
// Every position i >= SPAN merges its (G, P) pair with the pair SPAN
// positions below it. Positions below SPAN already hold their final prefix
// and pass through unchanged.
module ksa_prefix_level
  import ksa_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SPAN  = 1
) (
  input  logic [WIDTH-1:0] g_i,
  input  logic [WIDTH-1:0] p_i,
  output logic [WIDTH-1:0] g_o,
  output logic [WIDTH-1:0] p_o
);

  // Black-cell merge for each position that has a partner SPAN bits below.
  always_comb begin
    g_o = g_i;
    p_o = p_i;
    for (int i = SPAN; i < WIDTH; i++) begin
      g_o[i] = g_i[i] | (p_i[i] & g_i[i-SPAN]);
      p_o[i] = p_i[i] & p_i[i-SPAN];
    end
  end

endmodule

// File: rtl/ksa_pipe.sv
// Fully pipelined Kogge-Stone adder/subtractor with a valid/ready stream.
// Stage 0 forms bitwise generate/propagate and folds the carry-in into bit 0.
// Stages 1..LEVELS each register one prefix level. A final register stage
// forms sum, cout and ovf. The whole pipe shifts together whenever the output
// is empty or being taken. Otherwise every stage holds, so bubbles stay where
// they are.
module ksa_pipe
  import ksa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int LEVELS = levels_f(WIDTH);

  // Per-stage record. g/p evolve through the prefix tree. p0 keeps the
  // original bitwise propagate for the final XOR. c0 is the effective
  // carry-in, needed again as the carry into bit 0.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] p0;
    logic             c0;
  } stage_t;

  stage_t           stg_q [0:LEVELS];
  stage_t           entry_d;
  stage_t           lvl_d [1:LEVELS];
  logic [WIDTH-1:0] lvlG [1:LEVELS];
  logic [WIDTH-1:0] lvlP [1:LEVELS];
  logic [WIDTH-1:0] bMod;
  logic             advance;

  logic             outValid_q;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             unusedFinalP;

  // The pipe can move when the output slot is empty or being consumed.
  assign advance  = !outValid_q | out_ready;
  assign in_ready = advance;

  // Entry stage. Invert b for subtraction and force the carry-in to 1.
  // The carry-in then becomes a generate at bit 0.
  always_comb begin
    bMod           = sub ? ~b : b;
    entry_d.valid  = in_valid;
    entry_d.c0     = sub | cin;
    entry_d.p      = a ^ bMod;
    entry_d.p0     = a ^ bMod;
    entry_d.g      = a & bMod;
    entry_d.g[0]   = entry_d.g[0] | (entry_d.p[0] & entry_d.c0);
  end

  // One prefix level per pipeline stage. The span doubles each level.
  for (genvar k = 1; k <= LEVELS; k++) begin : g_level
    ksa_prefix_level #(
      .WIDTH (WIDTH),
      .SPAN  (1 << (k - 1))
    ) u_level (
      .g_i (stg_q[k-1].g),
      .p_i (stg_q[k-1].p),
      .g_o (lvlG[k]),
      .p_o (lvlP[k])
    );
    assign lvl_d[k] = {stg_q[k-1].valid, lvlG[k], lvlP[k], stg_q[k-1].p0, stg_q[k-1].c0};
  end

  // Final stage. After the full tree, g[i] is the carry out of bit i.
  // The carry into bit i is therefore g[i-1], and bit 0 takes c0.
  always_comb begin
    sum_d  = stg_q[LEVELS].p0 ^ {stg_q[LEVELS].g[WIDTH-2:0], stg_q[LEVELS].c0};
    cout_d = stg_q[LEVELS].g[WIDTH-1];
    ovf_d  = stg_q[LEVELS].g[WIDTH-1] ^ stg_q[LEVELS].g[WIDTH-2];
  end

  // The group propagate leaving the last level has no consumer.
  assign unusedFinalP = ^stg_q[LEVELS].p;

  // Pipeline registers. Every stage shifts on advance and holds otherwise.
  // Reset clears everything, so valid bits and outputs never start as X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= LEVELS; k++) begin
        stg_q[k] <= '0;
      end
      outValid_q <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else if (advance) begin
      stg_q[0] <= entry_d;
      for (int k = 1; k <= LEVELS; k++) begin
        stg_q[k] <= lvl_d[k];
      end
      outValid_q <= stg_q[LEVELS].valid;
      sum_q      <= sum_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
    end
  end

  assign out_valid = outValid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
